// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, one byte per frame.
//
// The serial line is double-flopped and every decision uses the second flop
// (rx_s). Bits are sampled at mid-bit; the FSM returns to idle at the middle
// of the stop bit so a start edge that follows immediately is not missed.
//
// Optional feature: define UART_RX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit. Without it the receiver is
// plain 8N1 and parity_error is tied low.
//
// Ports:
//   clk            system clock, rising edge
//   reset_n        asynchronous active-low reset
//   rx_serial      asynchronous serial input, idles high
//   io_data_valid  one-cycle pulse: io_data_packet holds a new byte
//   io_data_packet last good byte, held until the next valid pulse
//   frame_error    one-cycle pulse: stop bit sampled low
//   parity_error   one-cycle pulse: parity mismatch (0 unless parity enabled)
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_serial,
    output logic       io_data_valid,
    output logic [7:0] io_data_packet,
    output logic       frame_error,
    output logic       parity_error
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } state_e;

    state_e          state;
    logic            rx_meta;
    logic            rx_s;
    logic [CntW-1:0] bit_cnt;
    logic [2:0]      idx;
    logic [7:0]      shift;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_serial;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_bad;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= StIdle;
            bit_cnt        <= '0;
            idx            <= '0;
            shift          <= '0;
            io_data_valid  <= 1'b0;
            io_data_packet <= 8'h00;
            frame_error    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error   <= 1'b0;
            parity_bad     <= 1'b0;
`endif
        end else begin
            io_data_valid <= 1'b0;
            frame_error   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error  <= 1'b0;
`endif
            unique case (state)
                StIdle: begin
                    if (!rx_s) begin
                        state   <= StStart;
                        bit_cnt <= '0;
                    end
                end
                StStart: begin
                    if (bit_cnt == HalfLast) begin
                        bit_cnt <= '0;
                        if (!rx_s) begin
                            state <= StData;
                            idx   <= '0;
                        end else begin
                            // Line went back high before mid-start: a glitch.
                            state <= StIdle;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CntW'(1);
                    end
                end
                StData: begin
                    if (bit_cnt == BitLast) begin
                        bit_cnt    <= '0;
                        shift[idx] <= rx_s;
                        if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= StParity;
`else
                            state <= StStop;
`endif
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CntW'(1);
                    end
                end
                StParity: begin
`ifdef UART_RX_PARITY_EN
                    if (bit_cnt == BitLast) begin
                        bit_cnt    <= '0;
                        parity_bad <= (rx_s != ^shift);
                        state      <= StStop;
                    end else begin
                        bit_cnt <= bit_cnt + CntW'(1);
                    end
`else
                    state <= StIdle;
`endif
                end
                StStop: begin
                    if (bit_cnt == BitLast) begin
                        bit_cnt <= '0;
                        if (rx_s) begin
                            state <= StIdle;
`ifdef UART_RX_PARITY_EN
                            if (parity_bad) begin
                                parity_error <= 1'b1;
                            end else begin
                                io_data_packet <= shift;
                                io_data_valid  <= 1'b1;
                            end
`else
                            io_data_packet <= shift;
                            io_data_valid  <= 1'b1;
`endif
                        end else begin
                            // Bad stop bit wins over any parity result.
                            frame_error <= 1'b1;
                            state       <= StBreak;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CntW'(1);
                    end
                end
                StBreak: begin
                    // Wait out a held-low line so it reports only one error.
                    if (rx_s) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx with CLKS_PER_BIT = 8.
module tb_uart_rx;

    localparam int unsigned Cpb = 8;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned NBits = 11;
`else
    localparam int unsigned NBits = 10;
`endif
    // Cycles from first low edge on rx_serial to the valid pulse.
    localparam int unsigned Lat = 2 + Cpb / 2 + (NBits - 1) * Cpb;

    logic       clk;
    logic       reset_n;
    logic       rx_serial;
    logic       io_data_valid;
    logic [7:0] io_data_packet;
    logic       frame_error;
    logic       parity_error;

    uart_rx #(
        .CLKS_PER_BIT(Cpb)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .rx_serial     (rx_serial),
        .io_data_valid (io_data_valid),
        .io_data_packet(io_data_packet),
        .frame_error   (frame_error),
        .parity_error  (parity_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_ferr = 0;
    int n_perr = 0;
    int last_valid_cyc = 0;
    int start_cyc = 0;
    logic [31:0] word = '0;
    logic [7:0]  exp_q[$];
    int          valid_cycs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: samples just after each rising edge, pops the scoreboard on valid.
    always begin
        @(posedge clk);
        #2;
        if (io_data_valid) begin
            n_valid++;
            last_valid_cyc = cyc;
            valid_cycs.push_back(cyc);
            word = {word[23:0], io_data_packet};
            check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("packet", 32'(io_data_packet), 32'(exp_q.pop_front()));
            end
        end
        if (frame_error) n_ferr++;
        if (parity_error) n_perr++;
        if (io_data_valid || frame_error) begin
            check("pulse_exclusive", 32'(io_data_valid & frame_error), 32'd0);
        end
    end

    // All drive tasks are entered at a falling edge and leave at one.
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx_serial = b;
        repeat (Cpb) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par);
`else
        if (par === 1'bx) $display("parity bit unknown");
`endif
        send_bit(stop);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        logic       exp_ferr;
    } vec_t;

    vec_t       tbl[4];
    int         v0, f0, p0;
    logic [7:0] last_good;

    initial begin
        tbl[0] = '{8'h93, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{8'hA5, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{8'h01, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{8'hC3, 1'b1, 1'b1, 1'b0};
        last_good = 8'h00;

        reset_n   = 1'b0;
        rx_serial = 1'b1;
        idle(3);
        check("rst_valid", 32'(io_data_valid), 32'd0);
        check("rst_packet", 32'(io_data_packet), 32'h00);
        check("rst_ferr", 32'(frame_error), 32'd0);
        check("rst_perr", 32'(parity_error), 32'd0);
        reset_n = 1'b1;
        idle(4);

        for (int i = 0; i < 4; i++) begin
            v0 = n_valid;
            f0 = n_ferr;
            p0 = n_perr;
            if (tbl[i].exp_valid) exp_q.push_back(tbl[i].data);
            send_frame(tbl[i].data, tbl[i].stop, ^tbl[i].data);
            if (!tbl[i].stop) idle(40);
            rx_serial = 1'b1;
            idle(2 * Cpb);
            check("tbl_valid_count", 32'(n_valid - v0), 32'(tbl[i].exp_valid));
            check("tbl_ferr_count", 32'(n_ferr - f0), 32'(tbl[i].exp_ferr));
            check("tbl_perr_count", 32'(n_perr - p0), 32'd0);
            if (tbl[i].exp_valid) begin
                check("tbl_latency", 32'(last_valid_cyc), 32'(start_cyc + 1 + Lat));
                last_good = tbl[i].data;
            end
            check("tbl_packet_hold", 32'(io_data_packet), 32'(last_good));
        end

        // Back-to-back frames, no idle gap.
        valid_cycs.delete();
        word = '0;
        v0 = n_valid;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h40);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h93);
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'h40, 1'b1, 1'b1);
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'h93, 1'b1, 1'b0);
        idle(2 * Cpb);
        check("b2b_count", 32'(n_valid - v0), 32'd4);
        check("b2b_word", word, 32'h00400093);
        if (valid_cycs.size() >= 4) begin
            for (int k = 1; k < 4; k++) begin
                check("b2b_spacing", 32'(valid_cycs[k] - valid_cycs[k-1]), 32'(NBits * Cpb));
            end
        end
        last_good = 8'h93;

        // Two-cycle glitch must be ignored, then a normal frame.
        v0 = n_valid;
        f0 = n_ferr;
        rx_serial = 1'b0;
        idle(2);
        rx_serial = 1'b1;
        idle(3 * Cpb);
        check("glitch_valid", 32'(n_valid - v0), 32'd0);
        check("glitch_ferr", 32'(n_ferr - f0), 32'd0);
        exp_q.push_back(8'h13);
        send_frame(8'h13, 1'b1, 1'b1);
        idle(2 * Cpb);
        check("glitch_next_count", 32'(n_valid - v0), 32'd1);
        check("glitch_next_latency", 32'(last_valid_cyc), 32'(start_cyc + 1 + Lat));
        last_good = 8'h13;

        // Reset during data bit 4 of 8'hFF.
        v0 = n_valid;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rx_serial = 1'b1;
        idle(3);
        reset_n = 1'b0;
        #1;
        check("midrst_valid", 32'(io_data_valid), 32'd0);
        check("midrst_packet", 32'(io_data_packet), 32'h00);
        check("midrst_ferr", 32'(frame_error), 32'd0);
        check("midrst_perr", 32'(parity_error), 32'd0);
        @(negedge clk);
        idle(3);
        reset_n = 1'b1;
        idle(4 * Cpb);
        check("midrst_no_byte", 32'(n_valid - v0), 32'd0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0);
        idle(2 * Cpb);
        check("midrst_next_count", 32'(n_valid - v0), 32'd1);
        check("midrst_next_packet", 32'(io_data_packet), 32'h5A);

`ifdef UART_RX_PARITY_EN
        v0 = n_valid;
        p0 = n_perr;
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        idle(2 * Cpb);
        check("par_ok_valid", 32'(n_valid - v0), 32'd1);
        check("par_ok_perr", 32'(n_perr - p0), 32'd0);
        send_frame(8'h07, 1'b1, 1'b0);
        idle(2 * Cpb);
        check("par_bad_valid", 32'(n_valid - v0), 32'd1);
        check("par_bad_perr", 32'(n_perr - p0), 32'd1);
        check("par_bad_hold", 32'(io_data_packet), 32'h07);
`endif

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial-to-byte UART receiver, 8N1 (8 data bits, no parity, 1 stop bit), LSB first.
- Sits directly upstream of uart_decoder. Its io_data_valid/io_data_packet outputs drive that block's inputs unchanged, so uart_decoder receives one byte per frame.
- Used to stream program bytes from a host PC into instruction memory.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200). Legal range is ≥ 4 and even. Simulation uses 8.

Ports:
- clk  in  1  system clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- rx_serial  in  1  asynchronous serial line; idles high.
- io_data_valid  out  1  one-cycle pulse: io_data_packet holds a new byte.
- io_data_packet  out  8  last received byte; held until the next valid pulse.
- frame_error  out  1  one-cycle pulse: stop bit sampled low.
- parity_error  out  1  one-cycle pulse on parity mismatch. Tied 0 when UART_RX_PARITY_EN is undefined.

Behaviour:
- Reset (async, reset_n low):
  - io_data_valid=0, io_data_packet=8'h00, frame_error=0, parity_error=0.
  - Both synchroniser flops = 1. State=IDLE. Counters and shift register = 0.
- Synchroniser:
  - rx_serial passes through 2 flops; rx_s is the second flop.
  - All decisions use rx_s only. This adds 2 cycles of latency.
- Counters:
  - bit_cnt is $clog2(CLKS_PER_BIT) bits wide.
  - idx is 3 bits and counts data bits 0..7.
- States:
  - IDLE: when rx_s==0, go to START with bit_cnt=0.
  - START:
    - bit_cnt increments each cycle.
    - At bit_cnt==CLKS_PER_BIT/2-1, sample rx_s.
    - Sample 0: go to DATA with bit_cnt=0, idx=0.
    - Sample 1: glitch/false start; go to IDLE with no output.
  - DATA:
    - At bit_cnt==CLKS_PER_BIT-1, sample rx_s into shift bit [idx], then bit_cnt=0.
    - When idx==7, go to STOP (or PARITY if enabled). Otherwise idx++.
  - STOP:
    - At bit_cnt==CLKS_PER_BIT-1, sample rx_s.
    - Sample 1: on that edge, io_data_packet<=shift and io_data_valid<=1 (one cycle); next state IDLE.
    - Sample 0: frame_error<=1 (one cycle); io_data_packet is not updated and no valid pulse. Next state BREAK.
  - BREAK: stay until rx_s==1, then go to IDLE. A held-low line therefore produces exactly one frame_error.
- Timing:
  - All samples are taken mid-bit.
  - Going to IDLE at the mid-point of the stop bit lets the next start edge be caught immediately. Back-to-back frames need no extra idle time.
- Latency: io_data_valid rises exactly 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the first clk edge at which rx_serial is low, plus CLKS_PER_BIT more with parity enabled.
- Pulses: io_data_valid and frame_error are never high in the same cycle. Each lasts exactly one cycle.
- Reset mid-frame: all state is discarded immediately, outputs return to reset values, and no partial byte is emitted.
- Line stuck low from reset: one START, then DATA/STOP run through, then frame_error, then BREAK. No io_data_valid.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP, sampled at bit_cnt==CLKS_PER_BIT-1.
  - Even parity: the expected bit is ^shift.
  - On mismatch, parity_error pulses for one cycle in the cycle io_data_valid would have pulsed. io_data_valid is suppressed and io_data_packet is not updated.
  - Frame error takes precedence over parity error: on a bad stop bit, only frame_error pulses.
- When undefined: 8N1 only, no PARITY state, parity_error is constant 0.

Test Plan (CLKS_PER_BIT=8):
- Send 8'h93 as an 8N1 frame → exactly one io_data_valid pulse with io_data_packet=8'h93, at 2+4+72=78 cycles after the start edge. frame_error stays 0.
- Send 8'h00, 8'h40, 8'h00, 8'h93 back-to-back with no idle gap → four valid pulses carrying those values in order, spaced ~80 cycles apart. The chained uart_decoder outputs word 32'h00400093.
- Drive rx_serial low for 2 cycles, then high → no io_data_valid, no frame_error; the block returns to IDLE and then correctly receives 8'h13.
- Send 8'hA5 with the stop bit driven 0, then hold the line low for 40 cycles → one frame_error pulse, no valid pulse, io_data_packet keeps its previous value. A following 8'h01 frame is received correctly.
- Assert reset_n=0 during data bit 4 of 8'hFF → all outputs 0 immediately. After release, an 8'h5A frame is received correctly and no 8'hFF is emitted.
- With UART_RX_PARITY_EN defined:
  - Send 8'h07 with parity bit 1 → valid pulse, packet 8'h07.
  - Send the same frame with parity bit 0 → parity_error pulse, no valid pulse.
